imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate-extension unit for the decode stage.
- Takes a full 32-bit instruction word and an extension mode. Produces a DATA_W-bit extended immediate one cycle later.
- Adds wide-move (MOVZ/MOVK halfword shift), shifted ALU immediates and optional branch-offset scaling.
- Uses a valid/ready handshake with a 2-entry skid buffer so decode stalls never drop an instruction; a flush input squashes in-flight entries.

---
 rtl/imm_ext_pkg.sv | 30 +++
 rtl/imm_ext_pipe_if.sv | 25 ++
 rtl/imm_ext_core.sv | 60 ++++++
 rtl/imm_ext_pipe.sv | 77 +++++++
 tb/tb_imm_ext_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension unit: mode encoding and
// instruction field positions.
package imm_ext_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    ALU_IMM    = 3'd0,
    DT_ADDR    = 3'd1,
    B_ADDR     = 3'd2,
    CB_ADDR    = 3'd3,
    IW_MOV     = 3'd4,
    ALU_IMM_SH = 3'd5
  } imm_mode_e;

  localparam int IMM12_MSB = 21;
  localparam int IMM12_LSB = 10;
  localparam int DT_MSB    = 20;
  localparam int DT_LSB    = 12;
  localparam int B_MSB     = 25;
  localparam int B_LSB     = 0;
  localparam int CB_MSB    = 23;
  localparam int CB_LSB    = 5;
  localparam int IW_MSB    = 20;
  localparam int IW_LSB    = 5;
  localparam int HW_MSB    = 22;
  localparam int HW_LSB    = 21;
  localparam int SH_BIT    = 22;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle between the decoder front end and the immediate unit.
interface imm_ext_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [MODE_W-1:0] in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic              out_err;

  modport master (
    output in_valid, in_instr, in_mode, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_mode, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extraction: builds a 64-bit result, then truncates
// to DATA_W. Illegal modes and unreachable halfword shifts force imm to 0.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter bit SCALE_BR = 1'b1
) (
  input  logic [31:0]       i_instr,
  input  logic [MODE_W-1:0] i_mode,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_err
);

  localparam int DT_W = DT_MSB - DT_LSB + 1;
  localparam int B_W  = B_MSB - B_LSB + 1;
  localparam int CB_W = CB_MSB - CB_LSB + 1;
  localparam int IW_W = IW_MSB - IW_LSB + 1;
  localparam int I12W = IMM12_MSB - IMM12_LSB + 1;

  logic [63:0] w_ext;
  logic        w_err;
  logic [11:0] w_imm12;
  logic        w_unused;

  assign w_imm12  = i_instr[IMM12_MSB:IMM12_LSB];
  assign w_unused = ^i_instr[31:B_MSB+1];

  always_comb begin
    w_ext = '0;
    w_err = 1'b0;
    case (imm_mode_e'(i_mode))
      ALU_IMM: w_ext = {{(64-I12W){1'b0}}, w_imm12};
      DT_ADDR: w_ext = {{(64-DT_W){i_instr[DT_MSB]}}, i_instr[DT_MSB:DT_LSB]};
      B_ADDR: begin
        w_ext = {{(64-B_W){i_instr[B_MSB]}}, i_instr[B_MSB:B_LSB]};
        if (SCALE_BR) w_ext = w_ext << 2;
      end
      CB_ADDR: begin
        w_ext = {{(64-CB_W){i_instr[CB_MSB]}}, i_instr[CB_MSB:CB_LSB]};
        if (SCALE_BR) w_ext = w_ext << 2;
      end
      IW_MOV: begin
        w_ext = {{(64-IW_W){1'b0}}, i_instr[IW_MSB:IW_LSB]} << {i_instr[HW_MSB:HW_LSB], 4'b0000};
        // Halfwords 2 and 3 fall entirely outside a 32-bit result
        if (DATA_W == 32 && i_instr[HW_MSB]) w_err = 1'b1;
      end
      ALU_IMM_SH: begin
        if (i_instr[SH_BIT]) w_ext = {{(52-I12W){1'b0}}, w_imm12, 12'b0};
        else                 w_ext = {{(64-I12W){1'b0}}, w_imm12};
      end
      default: w_err = 1'b1;
    endcase
    if (w_err) w_ext = '0;
  end

  assign o_imm = w_ext[DATA_W-1:0];
  assign o_err = w_err;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage: main output register plus one skid
// entry so a stalled consumer never causes an accepted instruction to be lost.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter bit SCALE_BR = 1'b1
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  imm_ext_pipe_if.slave  bus
);

  logic [DATA_W-1:0] w_imm;
  logic              w_err;
  logic              w_in_fire;
  logic              w_out_fire;

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_imm;
  logic              r_main_err;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_imm;
  logic              r_skid_err;

  imm_ext_core #(
    .DATA_W   (DATA_W),
    .SCALE_BR (SCALE_BR)
  ) u_core (
    .i_instr (bus.in_instr),
    .i_mode  (bus.in_mode),
    .o_imm   (w_imm),
    .o_err   (w_err)
  );

  // Ready depends only on stored state (and reset), never on out_ready
  assign bus.in_ready  = !r_skid_valid && !reset;
  assign w_in_fire     = bus.in_valid && bus.in_ready;
  assign w_out_fire    = r_main_valid && bus.out_ready;

  assign bus.out_valid = r_main_valid;
  assign bus.out_imm   = r_main_imm;
  assign bus.out_err   = r_main_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_err   <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= r_skid_imm;
        r_main_err   <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= w_imm;
        r_main_err   <= w_err;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_err   <= w_err;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 64-bit/scaled and a 32-bit/unscaled instance share
// one stimulus stream; a scoreboard checks both against an arithmetic model.
module tb_imm_ext_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic        clk;
  logic        tb_reset;
  logic        tb_flush;
  logic        tb_in_valid;
  logic [31:0] tb_instr;
  logic [2:0]  tb_mode;
  logic        tb_out_ready;
  logic        rand_ready;
  logic        started;
  logic        last_acc;

  int total;
  int bad;

  exp_t q64[$];
  exp_t q32[$];

  imm_ext_pipe_if #(.DATA_W(64)) if64 ();
  imm_ext_pipe_if #(.DATA_W(32)) if32 ();

  assign if64.in_valid  = tb_in_valid;
  assign if64.in_instr  = tb_instr;
  assign if64.in_mode   = tb_mode;
  assign if64.out_ready = tb_out_ready;
  assign if32.in_valid  = tb_in_valid;
  assign if32.in_instr  = tb_instr;
  assign if32.in_mode   = tb_mode;
  assign if32.out_ready = tb_out_ready;

  imm_ext_pipe #(.DATA_W(64), .SCALE_BR(1'b1)) dut64 (
    .clk   (clk),
    .reset (tb_reset),
    .flush (tb_flush),
    .bus   (if64)
  );

  imm_ext_pipe #(.DATA_W(32), .SCALE_BR(1'b0)) dut32 (
    .clk   (clk),
    .reset (tb_reset),
    .flush (tb_flush),
    .bus   (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the field values
  function automatic exp_t ref_ext(input logic [31:0] i, input logic [2:0] m,
                                   input int w, input bit sc);
    exp_t   e;
    longint v;
    v     = 0;
    e.err = 1'b0;
    case (m)
      3'd0: v = longint'(i[21:10]);
      3'd1: begin
        v = longint'(i[20:12]);
        if (v >= 256) v = v - 512;
      end
      3'd2: begin
        v = longint'(i[25:0]);
        if (v >= (64'd1 << 25)) v = v - (64'sd1 << 26);
        if (sc) v = v * 4;
      end
      3'd3: begin
        v = longint'(i[23:5]);
        if (v >= (64'd1 << 18)) v = v - (64'sd1 << 19);
        if (sc) v = v * 4;
      end
      3'd4: begin
        v = longint'(i[20:5]) * (64'sd1 << (16 * int'(i[22:21])));
        if (w == 32 && i[22:21] >= 2'd2) e.err = 1'b1;
      end
      3'd5: v = longint'(i[21:10]) * (i[22] ? 64'sd4096 : 64'sd1);
      default: e.err = 1'b1;
    endcase
    if (e.err) v = 0;
    e.imm = 64'(v);
    if (w == 32) e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
    return e;
  endfunction

  // Scoreboard monitor: queue occupancy is the expected pipe occupancy
  always @(negedge clk) begin
    if (started && !tb_reset) begin
      check("in_ready64", 64'(if64.in_ready), 64'(q64.size() < 2));
      check("in_ready32", 64'(if32.in_ready), 64'(q32.size() < 2));
      check("out_valid64", 64'(if64.out_valid), 64'(q64.size() != 0));
      check("out_valid32", 64'(if32.out_valid), 64'(q32.size() != 0));
      if (if64.out_valid && q64.size() != 0) begin
        check("imm64", if64.out_imm, q64[0].imm);
        check("err64", 64'(if64.out_err), 64'(q64[0].err));
        if (tb_out_ready) void'(q64.pop_front());
      end
      if (if32.out_valid && q32.size() != 0) begin
        check("imm32", {32'b0, if32.out_imm}, q32[0].imm);
        check("err32", 64'(if32.out_err), 64'(q32[0].err));
        if (tb_out_ready) void'(q32.pop_front());
      end
    end
  end

  task automatic cycle();
    logic        acc;
    logic        clr;
    logic [31:0] ci;
    logic [2:0]  cm;
    @(negedge clk);
    acc = tb_in_valid && if64.in_ready && !tb_flush && !tb_reset;
    clr = tb_flush || tb_reset;
    ci  = tb_instr;
    cm  = tb_mode;
    @(posedge clk);
    #1;
    if (clr) begin
      q64.delete();
      q32.delete();
    end
    if (acc) begin
      q64.push_back(ref_ext(ci, cm, 64, 1'b1));
      q32.push_back(ref_ext(ci, cm, 32, 1'b0));
    end
    last_acc = acc;
    if (rand_ready) tb_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] instr, input logic [2:0] mode);
    tb_in_valid = 1'b1;
    tb_instr    = instr;
    tb_mode     = mode;
    last_acc    = 1'b0;
    for (int n = 0; n < 64; n++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 64'd0, 64'd1);
    tb_in_valid = 1'b0;
  endtask

  // Pipe empty and out_ready=1: result must be visible right after the accept edge
  task automatic send_chk(input logic [31:0] instr, input logic [2:0] mode,
                          input logic [63:0] e64, input logic r64,
                          input logic [63:0] e32, input logic r32);
    send(instr, mode);
    check("lat_valid64", 64'(if64.out_valid), 64'd1);
    check("dir_imm64", if64.out_imm, e64);
    check("dir_err64", 64'(if64.out_err), 64'(r64));
    check("dir_imm32", {32'b0, if32.out_imm}, e32);
    check("dir_err32", 64'(if32.out_err), 64'(r32));
  endtask

  task automatic drain();
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (q64.size() == 0 && q32.size() == 0) break;
      cycle();
    end
    check("drain", 64'(q64.size() + q32.size()), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    tb_reset = 1'b1; tb_flush = 1'b0; tb_in_valid = 1'b0;
    tb_instr = '0; tb_mode = '0; tb_out_ready = 1'b1;
    rand_ready = 1'b0; started = 1'b0; last_acc = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(if64.out_valid), 64'd0);
    check("rst_out_imm", if64.out_imm, 64'd0);
    check("rst_out_err", 64'(if64.out_err), 64'd0);
    check("rst_in_ready", 64'(if64.in_ready), 64'd0);
    tb_reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(if64.in_ready), 64'd1);
    started = 1'b1;

    send_chk(32'h03FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF, 1'b0);
    send_chk(32'h0000_0020, 3'd3, 64'h4, 1'b0, 64'h1, 1'b0);
    send_chk(32'h0010_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 64'hFFFF_FF00, 1'b0);
    send_chk(32'h003F_FC00, 3'd0, 64'hFFF, 1'b0, 64'hFFF, 1'b0);
    send_chk(32'h0077_DDE0, 3'd4, 64'hBEEF_0000_0000_0000, 1'b0, 64'h0, 1'b1);
    send_chk(32'h0057_DDE0, 3'd4, 64'h0000_BEEF_0000_0000, 1'b0, 64'h0, 1'b1);
    send_chk(32'h0040_0400, 3'd5, 64'h1000, 1'b0, 64'h1000, 1'b0);
    send_chk(32'hFFFF_FFFF, 3'd6, 64'h0, 1'b1, 64'h0, 1'b1);
    send_chk(32'h0200_0000, 3'd2, 64'hFFFF_FFFF_F800_0000, 1'b0, 64'hFE00_0000, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) send($urandom, 3'($urandom_range(0, 7)));
    rand_ready = 1'b0;
    drain();

    // Backpressure: four entries while the consumer stalls for three cycles
    tb_out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0400, 3'd0);
        send(32'h0000_0800, 3'd0);
        check("bp_in_ready", 64'(if64.in_ready), 64'd0);
        send(32'h0000_0C00, 3'd0);
        send(32'h0000_1000, 3'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #2 tb_out_ready = 1'b1;
      end
    join
    drain();

    // Flush with main and skid full and a third entry offered
    tb_out_ready = 1'b0;
    send(32'h0012_3400, 3'd5);
    send(32'h0056_7800, 3'd5);
    tb_in_valid = 1'b1;
    tb_instr    = 32'h0009_9C00;
    tb_mode     = 3'd0;
    tb_flush    = 1'b1;
    cycle();
    tb_flush    = 1'b0;
    tb_in_valid = 1'b0;
    check("flush_out_valid", 64'(if64.out_valid), 64'd0);
    check("flush_in_ready", 64'(if64.in_ready), 64'd1);
    tb_out_ready = 1'b1;
    repeat (5) cycle();

    // Reset mid-stream
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) send($urandom, 3'($urandom_range(0, 5)));
    rand_ready  = 1'b0;
    tb_in_valid = 1'b1;
    tb_reset    = 1'b1;
    cycle();
    tb_in_valid = 1'b0;
    check("mid_rst_out_valid", 64'(if64.out_valid), 64'd0);
    check("mid_rst_out_imm", if64.out_imm, 64'd0);
    check("mid_rst_in_ready", 64'(if64.in_ready), 64'd0);
    tb_reset = 1'b0;
    #1;
    check("mid_rst_in_ready_after", 64'(if64.in_ready), 64'd1);
    tb_out_ready = 1'b1;
    send_chk(32'h0000_0040, 3'd3, 64'h8, 1'b0, 64'h2, 1'b0);
    drain();
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
